// File: rtl/image_proc_engine_if.sv
// Bus bundle between image_proc_engine and its controller and pixel memories.
interface image_proc_engine_if #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned ROW_W = 6,
   parameter int unsigned COL_W = 6
);
   logic             start;
   logic [2:0]       mode;
   logic [PIX_W-1:0] param;
   logic [PIX_W-1:0] in_pix;
   logic [ROW_W-1:0] in_row;
   logic [COL_W-1:0] in_col;
   logic [ROW_W-1:0] out_row;
   logic [COL_W-1:0] out_col;
   logic             out_we;
   logic [PIX_W-1:0] out_pix;
   logic             busy;
   logic             done;

   // Controller / memory side
   modport master (
      output start, mode, param, in_pix,
      input  in_row, in_col, out_row, out_col, out_we, out_pix, busy, done
   );

   // Engine side
   modport slave (
      input  start, mode, param, in_pix,
      output in_row, in_col, out_row, out_col, out_we, out_pix, busy, done
   );
endinterface

// File: rtl/image_proc_engine.sv
// Raster image engine: scans a source image and writes one processed pixel per cycle.
module image_proc_engine #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned ROW_W = 6,
   parameter int unsigned COL_W = 6
) (
   input  logic                clk,
   input  logic                reset,
   image_proc_engine_if.slave  bus
);
   localparam int unsigned AW    = ROW_W + COL_W;
   localparam int unsigned SUM_W = PIX_W + 2;
   localparam logic [AW-1:0]    LAST_ADDR = '1;
   localparam logic [COL_W-1:0] MAXC      = '1;
   localparam logic [PIX_W-1:0] MAXP      = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [2:0]       mode_q, mode_d;
   logic [PIX_W-1:0] param_q, param_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   // read stage: address whose data is on in_pix this cycle
   logic             rd_v_q, rd_v_d;
   logic [ROW_W-1:0] rd_row_q, rd_row_d;
   logic [COL_W-1:0] rd_col_q, rd_col_d;
   // blur stage: centre pixel waiting for its right neighbour
   logic             cur_v_q, cur_v_d;
   logic [ROW_W-1:0] cur_row_q, cur_row_d;
   logic [COL_W-1:0] cur_col_q, cur_col_d;
   logic [PIX_W-1:0] cur_pix_q, cur_pix_d;
   logic [PIX_W-1:0] prev_pix_q, prev_pix_d;
   // write port
   logic             out_we_q, out_we_d;
   logic [ROW_W-1:0] out_row_q, out_row_d;
   logic [COL_W-1:0] out_col_q, out_col_d;
   logic [PIX_W-1:0] out_pix_q, out_pix_d;

   logic             blur_mode;
   logic             mirror_mode;
   logic [PIX_W:0]   add_sum;
   logic [PIX_W-1:0] point_pix;
   logic [PIX_W-1:0] blur_l, blur_r;
   logic [SUM_W-1:0] blur_sum;
   logic [PIX_W-1:0] blur_pix;

   assign blur_mode   = (mode_q == 3'd5);
   assign mirror_mode = (mode_q == 3'd4);

   // Point operations on the pixel currently returned by the source memory
   always_comb begin
      add_sum   = {1'b0, bus.in_pix} + {1'b0, param_q};
      point_pix = bus.in_pix;
      case (mode_q)
         3'd1:    point_pix = ~bus.in_pix;
         3'd2:    point_pix = (bus.in_pix >= param_q) ? MAXP : '0;
         3'd3:    point_pix = add_sum[PIX_W] ? MAXP : add_sum[PIX_W-1:0];
         3'd6:    point_pix = (bus.in_pix >= param_q) ? (bus.in_pix - param_q) : '0;
         default: point_pix = bus.in_pix;
      endcase
   end

   // 1-2-1 blur with edge replication; the right neighbour is the live memory data
   always_comb begin
      blur_l   = (cur_col_q == '0)  ? cur_pix_q : prev_pix_q;
      blur_r   = (cur_col_q == MAXC) ? cur_pix_q : bus.in_pix;
      blur_sum = SUM_W'(blur_l) + (SUM_W'(cur_pix_q) << 1) + SUM_W'(blur_r);
      blur_pix = PIX_W'(blur_sum >> 2);
   end

   // Next-state, address generation, pipeline advance and write port
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      mode_d     = mode_q;
      param_d    = param_q;
      busy_d     = busy_q;
      done_d     = done_q;
      rd_v_d     = (state_q == ST_SCAN);
      rd_row_d   = addr_q[AW-1:COL_W];
      rd_col_d   = addr_q[COL_W-1:0];
      cur_v_d    = rd_v_q;
      cur_row_d  = rd_row_q;
      cur_col_d  = rd_col_q;
      cur_pix_d  = bus.in_pix;
      prev_pix_d = cur_pix_q;
      out_we_d   = 1'b0;
      out_row_d  = out_row_q;
      out_col_d  = out_col_q;
      out_pix_d  = out_pix_q;

      if (blur_mode) begin
         if (cur_v_q) begin
            out_we_d  = 1'b1;
            out_row_d = cur_row_q;
            out_col_d = cur_col_q;
            out_pix_d = blur_pix;
         end
      end else if (rd_v_q) begin
         out_we_d  = 1'b1;
         out_row_d = rd_row_q;
         out_col_d = mirror_mode ? (MAXC - rd_col_q) : rd_col_q;
         out_pix_d = point_pix;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_SCAN;
               addr_d  = '0;
               mode_d  = bus.mode;
               param_d = bus.param;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         ST_SCAN: begin
            addr_d = addr_q + AW'(1);
            if (addr_q == LAST_ADDR) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!rd_v_q && (!blur_mode || !cur_v_q)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         mode_q     <= '0;
         param_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_v_q     <= 1'b0;
         rd_row_q   <= '0;
         rd_col_q   <= '0;
         cur_v_q    <= 1'b0;
         cur_row_q  <= '0;
         cur_col_q  <= '0;
         cur_pix_q  <= '0;
         prev_pix_q <= '0;
         out_we_q   <= 1'b0;
         out_row_q  <= '0;
         out_col_q  <= '0;
         out_pix_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         mode_q     <= mode_d;
         param_q    <= param_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_v_q     <= rd_v_d;
         rd_row_q   <= rd_row_d;
         rd_col_q   <= rd_col_d;
         cur_v_q    <= cur_v_d;
         cur_row_q  <= cur_row_d;
         cur_col_q  <= cur_col_d;
         cur_pix_q  <= cur_pix_d;
         prev_pix_q <= prev_pix_d;
         out_we_q   <= out_we_d;
         out_row_q  <= out_row_d;
         out_col_q  <= out_col_d;
         out_pix_q  <= out_pix_d;
      end
   end

   assign bus.in_row  = addr_q[AW-1:COL_W];
   assign bus.in_col  = addr_q[COL_W-1:0];
   assign bus.out_row = out_row_q;
   assign bus.out_col = out_col_q;
   assign bus.out_we  = out_we_q;
   assign bus.out_pix = out_pix_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_image_proc_engine.sv
// Directed bench for image_proc_engine on a 64x64 8-bit image.
module tb_image_proc_engine;
   localparam int NPIX = 4096;

   logic clk;
   logic reset;

   image_proc_engine_if #(.PIX_W(8), .ROW_W(6), .COL_W(6)) bus ();

   image_proc_engine #(.PIX_W(8), .ROW_W(6), .COL_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0] mode;
      logic [7:0] param;
      int         idx;
      logic [7:0] exp;
   } vec_t;

   logic [7:0] src [0:NPIX-1];
   logic [7:0] dst [0:NPIX-1];
   bit         wr  [0:NPIX-1];
   vec_t       vecs [0:24];

   int n_checks = 0;
   int n_fail   = 0;
   int first_we, done_at, nwrites, dups;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read source memory, one cycle latency
   always @(posedge clk) bus.in_pix <= src[{bus.in_row, bus.in_col}];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] blur_ref(input int r, input int c);
      int x, l, rr;
      x  = int'(src[r*64 + c]);
      l  = (c == 0)  ? x : int'(src[r*64 + c - 1]);
      rr = (c == 63) ? x : int'(src[r*64 + c + 1]);
      return 8'((l + 2*x + rr) >> 2);
   endfunction

   task automatic load_ramp();
      for (int i = 0; i < NPIX; i++) src[i] = 8'(i);
   endtask

   // Issue start at a negedge; returns just after the accepting edge E0
   task automatic start_pass(input logic [2:0] m, input logic [7:0] p, input bit hold);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.param = p;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
   endtask

   // Run a full pass, capture every write, and record timing relative to E0
   task automatic run_pass(input logic [2:0] m, input logic [7:0] p, input bit disturb, input bit hold);
      for (int i = 0; i < NPIX; i++) begin
         wr[i]  = 1'b0;
         dst[i] = 8'h00;
      end
      first_we = -1;
      done_at  = -1;
      nwrites  = 0;
      dups     = 0;
      start_pass(m, p, hold);
      check("e0_busy", 32'(bus.busy), 32'd1);
      check("e0_done", 32'(bus.done), 32'd0);
      check("e0_addr", 32'({bus.in_row, bus.in_col}), 32'd0);
      for (int k = 1; k <= 5000; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_we) begin
            int a;
            a = int'({bus.out_row, bus.out_col});
            if (first_we < 0) first_we = k;
            if (wr[a]) dups++;
            wr[a]  = 1'b1;
            dst[a] = bus.out_pix;
            nwrites++;
         end
         if (bus.done) begin
            done_at = k;
            break;
         end
         if (disturb && k == 10) begin
            bus.start = 1'b1;
            bus.mode  = 3'd1;
            bus.param = 8'd77;
         end
         if (disturb && k == 11) bus.start = 1'b0;
      end
   endtask

   task automatic check_copy(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < NPIX; i++) if (dst[i] !== src[i]) bad++;
      check(name, 32'(bad), 32'd0);
   endtask

   initial begin
      // Point-operation vectors: pixels 0,99,100,200,255 sit at indices 0..4
      vecs[0]  = '{3'd1, 8'd100, 0, 8'd255};
      vecs[1]  = '{3'd1, 8'd100, 1, 8'd156};
      vecs[2]  = '{3'd1, 8'd100, 2, 8'd155};
      vecs[3]  = '{3'd1, 8'd100, 3, 8'd55};
      vecs[4]  = '{3'd1, 8'd100, 4, 8'd0};
      vecs[5]  = '{3'd2, 8'd100, 0, 8'd0};
      vecs[6]  = '{3'd2, 8'd100, 1, 8'd0};
      vecs[7]  = '{3'd2, 8'd100, 2, 8'd255};
      vecs[8]  = '{3'd2, 8'd100, 3, 8'd255};
      vecs[9]  = '{3'd2, 8'd100, 4, 8'd255};
      vecs[10] = '{3'd3, 8'd100, 0, 8'd100};
      vecs[11] = '{3'd3, 8'd100, 1, 8'd199};
      vecs[12] = '{3'd3, 8'd100, 2, 8'd200};
      vecs[13] = '{3'd3, 8'd100, 3, 8'd255};
      vecs[14] = '{3'd3, 8'd100, 4, 8'd255};
      vecs[15] = '{3'd6, 8'd100, 0, 8'd0};
      vecs[16] = '{3'd6, 8'd100, 1, 8'd0};
      vecs[17] = '{3'd6, 8'd100, 2, 8'd0};
      vecs[18] = '{3'd6, 8'd100, 3, 8'd100};
      vecs[19] = '{3'd6, 8'd100, 4, 8'd155};
      vecs[20] = '{3'd7, 8'd100, 0, 8'd0};
      vecs[21] = '{3'd7, 8'd100, 1, 8'd99};
      vecs[22] = '{3'd7, 8'd100, 2, 8'd100};
      vecs[23] = '{3'd7, 8'd100, 3, 8'd200};
      vecs[24] = '{3'd7, 8'd100, 4, 8'd255};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 3'd0;
      bus.param = 8'd0;
      load_ramp();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",   32'(bus.busy),    32'd0);
      check("rst_done",   32'(bus.done),    32'd0);
      check("rst_we",     32'(bus.out_we),  32'd0);
      check("rst_inaddr", 32'({bus.in_row, bus.in_col}),   32'd0);
      check("rst_outaddr",32'({bus.out_row, bus.out_col}), 32'd0);
      check("rst_outpix", 32'(bus.out_pix), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Mode 0 copy on the ramp image
      run_pass(3'd0, 8'd0, 1'b0, 1'b0);
      check("copy_first_we", 32'(first_we), 32'd2);
      check("copy_done_at",  32'(done_at),  32'd4098);
      check("copy_writes",   32'(nwrites),  32'd4096);
      check("copy_dups",     32'(dups),     32'd0);
      check_copy("copy_data");

      // done is a level that holds, addresses parked at 0
      repeat (5) @(posedge clk);
      #1;
      check("hold_done",   32'(bus.done), 32'd1);
      check("hold_busy",   32'(bus.busy), 32'd0);
      check("hold_inaddr", 32'({bus.in_row, bus.in_col}), 32'd0);

      // Reset mid-pass
      begin
         int late_we;
         late_we = 0;
         start_pass(3'd0, 8'd0, 1'b0);
         repeat (99) @(posedge clk);
         #2;
         reset = 1'b1;
         #1;
         check("midrst_we",      32'(bus.out_we),  32'd0);
         check("midrst_busy",    32'(bus.busy),    32'd0);
         check("midrst_done",    32'(bus.done),    32'd0);
         check("midrst_inaddr",  32'({bus.in_row, bus.in_col}),   32'd0);
         check("midrst_outaddr", 32'({bus.out_row, bus.out_col}), 32'd0);
         check("midrst_outpix",  32'(bus.out_pix), 32'd0);
         @(negedge clk);
         reset = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_we || bus.busy || bus.done) late_we++;
         end
         check("midrst_idle", 32'(late_we), 32'd0);
      end

      // Fresh pass after reset, with start pulse and mode change mid-pass
      run_pass(3'd0, 8'd0, 1'b1, 1'b0);
      check("dist_first_we", 32'(first_we), 32'd2);
      check("dist_done_at",  32'(done_at),  32'd4098);
      check("dist_writes",   32'(nwrites),  32'd4096);
      check_copy("dist_data");

      // Table-driven point operations
      src[0] = 8'd0;
      src[1] = 8'd99;
      src[2] = 8'd100;
      src[3] = 8'd200;
      src[4] = 8'd255;
      for (int i = 0; i < 25; i++) begin
         if (i % 5 == 0) begin
            run_pass(vecs[i].mode, vecs[i].param, 1'b0, 1'b0);
            check($sformatf("m%0d_done_at", vecs[i].mode), 32'(done_at), 32'd4098);
         end
         check($sformatf("vec%0d_m%0d", i, vecs[i].mode), 32'(dst[vecs[i].idx]), 32'(vecs[i].exp));
      end

      // Mode 4 horizontal mirror
      load_ramp();
      src[5*64] = 8'hAA;
      run_pass(3'd4, 8'd0, 1'b0, 1'b0);
      check("mir_pix_5_63", 32'(dst[5*64 + 63]), 32'hAA);
      check("mir_writes",   32'(nwrites), 32'd4096);
      check("mir_dups",     32'(dups),    32'd0);
      check("mir_done_at",  32'(done_at), 32'd4098);
      begin
         int bad;
         bad = 0;
         for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
               if (dst[r*64 + 63 - c] !== src[r*64 + c]) bad++;
         check("mir_data", 32'(bad), 32'd0);
      end

      // Mode 5 blur: row 0 = 10,20,...,640 mod 256; row 1 all 255
      load_ramp();
      for (int c = 0; c < 64; c++) begin
         src[c]      = 8'((c + 1) * 10);
         src[64 + c] = 8'd255;
      end
      run_pass(3'd5, 8'd0, 1'b0, 1'b0);
      check("blur_first_we", 32'(first_we), 32'd3);
      check("blur_done_at",  32'(done_at),  32'd4099);
      check("blur_writes",   32'(nwrites),  32'd4096);
      check("blur_col0",     32'(dst[0]),   32'd12);
      check("blur_col1",     32'(dst[1]),   32'd20);
      check("blur_col63",    32'(dst[63]),  32'd125);
      check("blur_row1_c0",  32'(dst[64]),  32'd255);
      begin
         int bad;
         bad = 0;
         for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
               if (dst[r*64 + c] !== blur_ref(r, c)) bad++;
         check("blur_data", 32'(bad), 32'd0);
      end

      // Start held high: the second pass begins only from DONE
      load_ramp();
      run_pass(3'd0, 8'd0, 1'b0, 1'b1);
      check("held_done_at", 32'(done_at), 32'd4098);
      check("held_writes",  32'(nwrites), 32'd4096);
      @(posedge clk);
      #1;
      check("restart_busy", 32'(bus.busy), 32'd1);
      check("restart_done", 32'(bus.done), 32'd0);
      check("restart_addr", 32'({bus.in_row, bus.in_col}), 32'd0);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("restart_addr1", 32'({bus.in_row, bus.in_col}), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
